if_fetch: RTL and testbench

//  Fetch-side requester for the IF-stage instruction memory. Drives the byte

---
 rtl/if_fetch.sv | 124 ++++++++++++
 tb/tb_if_fetch.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// IF-stage fetch requester: issues byte addresses to a registered instruction
// memory, decodes 8/16-bit instruction length and presents instructions to decode.
module if_fetch #(
  parameter int              PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              MEM_DEPTH = 11
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] pc,
  input  logic [3:0]      one,
  input  logic [3:0]      two,
  input  logic [3:0]      three,
  input  logic [3:0]      four,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [15:0]     inst,
  output logic            inst_len,
  output logic [PC_W-1:0] inst_pc,
  output logic            inst_valid,
  output logic            halted
);

  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    CAPTURE = 2'd1,
    HALT    = 2'd2
  } state_t;

  // A 16-bit fetch reads bytes pc and pc+1, so the last byte cannot start one.
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(MEM_DEPTH - 2);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_d;
  logic [15:0]     inst_d;
  logic            inst_len_d;
  logic [PC_W-1:0] inst_pc_d;
  logic            inst_valid_d;
  logic            halted_d;

  logic            accepted;
  logic            is_long;
  logic [15:0]     decoded;
  logic [PC_W-1:0] pc_step;

  assign accepted = inst_valid && !stall;
  assign is_long  = one[3];
  assign decoded  = is_long ? {one, two, three, four} : {one, two, 8'h00};
  assign pc_step  = is_long ? PC_W'(2) : PC_W'(1);

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d      = state_q;
    pc_d         = pc;
    inst_d       = inst;
    inst_len_d   = inst_len;
    inst_pc_d    = inst_pc;
    inst_valid_d = inst_valid;
    halted_d     = halted;

    if (accepted) inst_valid_d = 1'b0;

    if (redirect) begin
      // Redirect beats stall and any state; a pending instruction is dropped.
      pc_d         = redirect_pc;
      inst_valid_d = 1'b0;
      halted_d     = 1'b0;
      state_d      = ISSUE;
    end else begin
      unique case (state_q)
        ISSUE: begin
          if (pc > LAST_PC) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          // Nibbles on the inputs belong to pc; wait while decode is blocked.
          if (!(inst_valid && stall)) begin
            inst_d       = decoded;
            inst_len_d   = is_long;
            inst_pc_d    = pc;
            inst_valid_d = 1'b1;
            pc_d         = pc + pc_step;
            state_d      = ISSUE;
          end
        end
        HALT: begin
          halted_d = 1'b1;
        end
        default: begin
          state_d = ISSUE;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values computed before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ISSUE;
      pc         <= RESET_PC;
      inst       <= '0;
      inst_len   <= 1'b0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc         <= pc_d;
      inst       <= inst_d;
      inst_len   <= inst_len_d;
      inst_pc    <= inst_pc_d;
      inst_valid <= inst_valid_d;
      halted     <= halted_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: registered instruction-memory model, directed scenarios
// and a randomized stall/redirect run scored against an instruction-stream model.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [15:0] pc;
  logic [3:0]  one, two, three, four;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] inst;
  logic        inst_len;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic        halted;

  int vectors;
  int miscompares;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ins;
    logic        len;
  } rec_t;

  rec_t got[$];

  logic [7:0] mem [0:10];
  logic [7:0] b0, b1;

  if_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .one        (one),
    .two        (two),
    .three      (three),
    .four       (four),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst       (inst),
    .inst_len   (inst_len),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] img(input logic [15:0] a);
    if (a < 16'd11) return mem[a[3:0]];
    return 8'h00;
  endfunction

  // Instruction memory: samples pc on the edge, nibbles valid the next cycle.
  always @(posedge clk) begin
    b0 <= img(pc);
    b1 <= img(pc + 16'd1);
  end
  assign one   = b0[7:4];
  assign two   = b0[3:0];
  assign three = b1[7:4];
  assign four  = b1[3:0];

  // Reference decode of the instruction starting at byte a.
  function automatic rec_t ref_at(input logic [15:0] a);
    logic [7:0] x, y;
    rec_t r;
    x = img(a);
    y = img(a + 16'd1);
    r.pc  = a;
    r.len = x[7];
    r.ins = x[7] ? {x, y} : {x, 8'h00};
    return r;
  endfunction

  task automatic cycle();
    if (inst_valid && !stall) got.push_back({inst_pc, inst, inst_len});
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    got.delete();
  endtask

  task automatic wait_inst(input logic [15:0] want_pc);
    int n;
    n = 0;
    while (!(inst_valid && inst_pc == want_pc) && n < 60) begin
      cycle();
      n++;
    end
    if (n >= 60) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_inst timeout: inst_pc=%h valid=%0b, required valid inst at %h",
               inst_pc, inst_valid, want_pc);
    end
  endtask

  task automatic wait_halt();
    int n;
    n = 0;
    while (!halted && n < 60) begin
      cycle();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    repeat (2) @(negedge clk);
    vectors++; if (pc !== 16'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 0000", pc); end
    vectors++; if (inst !== 16'h0) begin miscompares++; $display("FAIL reset_inst: got %h want 0000", inst); end
    vectors++; if (inst_len !== 1'b0) begin miscompares++; $display("FAIL reset_len: got %b want 0", inst_len); end
    vectors++; if (inst_pc !== 16'h0) begin miscompares++; $display("FAIL reset_inst_pc: got %h want 0000", inst_pc); end
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b want 0", halted); end
  endtask

  task automatic test_stream();
    rec_t exp_list [9];
    exp_list = '{{16'd0, 16'h0000, 1'b0}, {16'd1, 16'h9182, 1'b1}, {16'd3, 16'h7300, 1'b0},
                 {16'd4, 16'h6400, 1'b0}, {16'd5, 16'h5500, 1'b0}, {16'd6, 16'h4600, 1'b0},
                 {16'd7, 16'h3700, 1'b0}, {16'd8, 16'h2800, 1'b0}, {16'd9, 16'h1900, 1'b0}};
    got.delete();
    rst = 1'b1;
    cycle();
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL latency_early: valid=%b want 0", inst_valid); end
    cycle();
    vectors++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0) begin
      miscompares++; $display("FAIL latency_first: valid=%b pc=%h want 1/0000", inst_valid, inst_pc);
    end
    repeat (30) cycle();
    vectors++; if (got.size() != 9) begin miscompares++; $display("FAIL stream_count: got %0d want 9", got.size()); end
    for (int i = 0; i < 9 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp_list[i]) begin
        miscompares++;
        $display("FAIL stream_%0d: got (%h,%h,%b) want (%h,%h,%b)", i, got[i].pc, got[i].ins,
                 got[i].len, exp_list[i].pc, exp_list[i].ins, exp_list[i].len);
      end
    end
    vectors++; if (halted !== 1'b1 || pc !== 16'd10) begin
      miscompares++; $display("FAIL stream_halt: halted=%b pc=%h want 1/000a", halted, pc);
    end
  endtask

  task automatic test_stall();
    do_reset();
    wait_inst(16'd1);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      vectors++;
      if (inst_valid !== 1'b1 || inst !== 16'h9182 || inst_pc !== 16'd1 || inst_len !== 1'b1 || pc !== 16'd3) begin
        miscompares++;
        $display("FAIL stall_hold_%0d: v=%b inst=%h ipc=%h len=%b pc=%h want 1/9182/0001/1/0003",
                 i, inst_valid, inst, inst_pc, inst_len, pc);
      end
    end
    stall = 1'b0;
    cycle();
    vectors++; if (inst_valid !== 1'b1 || inst_pc !== 16'd3) begin
      miscompares++; $display("FAIL stall_reload: v=%b ipc=%h want 1/0003", inst_valid, inst_pc);
    end
    cycle();
    vectors++; if (got.size() < 3 || got[$] !== rec_t'({16'd3, 16'h7300, 1'b0})) begin
      miscompares++; $display("FAIL stall_next: got (%h,%h,%b) want (0003,7300,0)", got[$].pc, got[$].ins, got[$].len);
    end
  endtask

  task automatic test_redirect_stall();
    int n;
    do_reset();
    wait_inst(16'd4);
    stall = 1'b1;
    repeat (2) cycle();
    redirect = 1'b1;
    redirect_pc = 16'd5;
    cycle();
    redirect = 1'b0;
    vectors++; if (inst_valid !== 1'b0 || pc !== 16'd5) begin
      miscompares++; $display("FAIL redirect_drop: v=%b pc=%h want 0/0005", inst_valid, pc);
    end
    stall = 1'b0;
    got.delete();
    n = 0;
    while (got.size() == 0 && n < 20) begin cycle(); n++; end
    vectors++; if (got.size() == 0 || got[0] !== rec_t'({16'd5, 16'h5500, 1'b0})) begin
      miscompares++; $display("FAIL redirect_next: count=%0d first=(%h,%h,%b) want (0005,5500,0)",
                              got.size(), got[0].pc, got[0].ins, got[0].len);
    end
  endtask

  task automatic test_halt_redirect();
    int n;
    wait_halt();
    vectors++; if (halted !== 1'b1 || pc !== 16'd10 || inst_valid !== 1'b0) begin
      miscompares++; $display("FAIL halt_state: halted=%b pc=%h v=%b want 1/000a/0", halted, pc, inst_valid);
    end
    redirect = 1'b1;
    redirect_pc = 16'd2;
    cycle();
    redirect = 1'b0;
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_exit: halted=%b want 0", halted); end
    got.delete();
    n = 0;
    while (got.size() == 0 && n < 20) begin cycle(); n++; end
    // Byte 2 is 0x82: top bit set, so it is a 16-bit instruction.
    vectors++; if (got.size() == 0 || got[0] !== rec_t'({16'd2, 16'h8273, 1'b1})) begin
      miscompares++; $display("FAIL halt_refetch: first=(%h,%h,%b) want (0002,8273,1)", got[0].pc, got[0].ins, got[0].len);
    end
    wait_halt();
    redirect = 1'b1;
    redirect_pc = 16'd10;
    cycle();
    redirect = 1'b0;
    vectors++; if (halted !== 1'b0 || pc !== 16'd10) begin
      miscompares++; $display("FAIL oor_redirect: halted=%b pc=%h want 0/000a", halted, pc);
    end
    cycle();
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL oor_halt: halted=%b want 1", halted); end
    got.delete();
    repeat (6) cycle();
    vectors++; if (got.size() != 0 || inst_valid !== 1'b0) begin
      miscompares++; $display("FAIL oor_quiet: accepted=%0d v=%b want 0/0", got.size(), inst_valid);
    end
  endtask

  task automatic test_reset_mid_capture();
    int n;
    do_reset();
    wait_inst(16'd3);
    repeat (2) cycle();
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (pc !== 16'h0 || inst !== 16'h0 || inst_len !== 1'b0 || inst_pc !== 16'h0 ||
        inst_valid !== 1'b0 || halted !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: pc=%h inst=%h len=%b ipc=%h v=%b h=%b want all 0",
               pc, inst, inst_len, inst_pc, inst_valid, halted);
    end
    @(negedge clk);
    rst = 1'b1;
    got.delete();
    n = 0;
    while (got.size() == 0 && n < 10) begin cycle(); n++; end
    vectors++; if (got.size() == 0 || got[0] !== rec_t'({16'd0, 16'h0000, 1'b0})) begin
      miscompares++; $display("FAIL reset_restart: count=%0d first=(%h,%h,%b) want (0000,0000,0)",
                              got.size(), got[0].pc, got[0].ins, got[0].len);
    end
  endtask

  // Scoreboard step: the accepted instruction must be the one at exp_pc;
  // a redirect on the same edge restarts the stream at its target.
  task automatic test_random();
    logic [15:0] exp_pc;
    rec_t        snap, want;
    logic        hold, acc;
    int          n;
    do_reset();
    exp_pc = 16'd0;
    for (int c = 0; c < 1400; c++) begin
      if (c < 1200) begin
        stall    = ($urandom_range(0, 99) < 40);
        redirect = ($urandom_range(0, 99) < 6);
        redirect_pc = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 12));
      end else begin
        stall = 1'b0;
        redirect = 1'b0;
      end
      acc  = inst_valid && !stall;
      hold = inst_valid && stall && !redirect;
      snap = {inst_pc, inst, inst_len};
      if (acc) begin
        vectors++;
        want = ref_at(exp_pc);
        if (exp_pc > 16'd9) begin
          miscompares++;
          $display("FAIL rand_past_end: accepted (%h,%h,%b) with stream at %h", inst_pc, inst, inst_len, exp_pc);
        end else if (snap !== want) begin
          miscompares++;
          $display("FAIL rand_inst: got (%h,%h,%b) want (%h,%h,%b)", snap.pc, snap.ins, snap.len,
                   want.pc, want.ins, want.len);
        end
        exp_pc = exp_pc + 16'd1 + {15'd0, want.len};
      end
      if (redirect) exp_pc = redirect_pc;
      @(negedge clk);
      if (hold) begin
        vectors++;
        if (inst_valid !== 1'b1 || {inst_pc, inst, inst_len} !== snap) begin
          miscompares++;
          $display("FAIL rand_stall_hold: v=%b got (%h,%h,%b) want (%h,%h,%b)", inst_valid,
                   inst_pc, inst, inst_len, snap.pc, snap.ins, snap.len);
        end
      end
    end
    n = 0;
    while (!halted && n < 40) begin @(negedge clk); n++; end
    vectors++; if (halted !== 1'b1 || inst_valid !== 1'b0 || pc !== exp_pc) begin
      miscompares++; $display("FAIL rand_drain: halted=%b v=%b pc=%h want 1/0/%h", halted, inst_valid, pc, exp_pc);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    mem = '{8'h00, 8'h91, 8'h82, 8'h73, 8'h64, 8'h55, 8'h46, 8'h37, 8'h28, 8'h19, 8'h00};
    test_reset();
    test_stream();
    test_stall();
    test_redirect_stall();
    test_halt_redirect();
    test_reset_mid_capture();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
